// File: rtl/dlx_mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data access unit.
package dlx_mem_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned WADDR_W = 30;

    // Big-endian: byte k of a word lives in lane LANE_TOP-k (counting from the LSB).
    localparam int unsigned LANE_TOP = LANES - 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_e;

    // Request fields held for the duration of an access.
    typedef struct packed {
        logic [1:0]      addr_lo;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] wdata;
    } req_cap_t;

    function automatic logic [4:0] lane_shift(input logic [1:0] k);
        return 5'((LANE_TOP - 32'(k)) * BYTE_W);
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Pipeline request/response and data SRAM interfaces for dmem_access_unit.
// DMEM_BYTE_EN_EN adds the sram_be lane enables.
interface dmem_req_if;
    import dlx_mem_pkg::*;

    logic            req_valid;
    logic            req_wr;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            mem_stall;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        output mem_stall, resp_valid, resp_rdata, resp_err
    );
endinterface

interface dmem_sram_if;
    import dlx_mem_pkg::*;

    logic [WADDR_W-1:0] sram_addr;
    logic               sram_rd;
    logic               sram_wr;
    logic [XLEN-1:0]    sram_wdata;
    logic [XLEN-1:0]    sram_rdata;
    logic               sram_ack;
`ifdef DMEM_BYTE_EN_EN
    logic [LANES-1:0]   sram_be;
`endif

    modport master (
        output sram_addr, sram_rd, sram_wr, sram_wdata,
`ifdef DMEM_BYTE_EN_EN
        output sram_be,
`endif
        input  sram_rdata, sram_ack
    );

    modport slave (
        input  sram_addr, sram_rd, sram_wr, sram_wdata,
`ifdef DMEM_BYTE_EN_EN
        input  sram_be,
`endif
        output sram_rdata, sram_ack
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: load extract/extend and sub-word store word build.
// With DMEM_BYTE_EN_EN the store word is the new data replicated across lanes plus enables.
module dmem_lane_align
    import dlx_mem_pkg::*;
(
    input  logic [1:0]       addr_lo_i,
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    input  logic [XLEN-1:0]  old_word_i,
    input  logic [XLEN-1:0]  new_data_i,
    output logic [XLEN-1:0]  load_data_o,
`ifdef DMEM_BYTE_EN_EN
    output logic [LANES-1:0] be_o,
`endif
    output logic [XLEN-1:0]  store_word_o
);

    logic [4:0]      sh;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] aligned;

    // Shift distance and right-justified field mask for the addressed lane(s).
    always_comb begin
        sh   = '0;
        mask = '1;
        case (size_i)
            SZ_BYTE: begin
                sh   = lane_shift(addr_lo_i);
                mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                sh   = addr_lo_i[1] ? 5'd0 : 5'd16;
                mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        lane_mask = mask << sh;
        aligned   = old_word_i >> sh;
    end

    always_comb begin
        load_data_o = aligned;
        case (size_i)
            SZ_BYTE: load_data_o = uns_i ? {24'h0, aligned[7:0]}
                                         : {{24{aligned[7]}}, aligned[7:0]};
            SZ_HALF: load_data_o = uns_i ? {16'h0, aligned[15:0]}
                                         : {{16{aligned[15]}}, aligned[15:0]};
            default: ;
        endcase
    end

`ifdef DMEM_BYTE_EN_EN
    always_comb begin
        case (size_i)
            SZ_BYTE: store_word_o = {4{new_data_i[7:0]}};
            SZ_HALF: store_word_o = {2{new_data_i[15:0]}};
            default: store_word_o = new_data_i;
        endcase
        for (int j = 0; j < int'(LANES); j++) begin
            be_o[j] = |lane_mask[j*8 +: 8];
        end
    end
`else
    assign store_word_o = (old_word_i & ~lane_mask) | ((new_data_i & mask) << sh);
`endif

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store responder driving a single-ported word SRAM with wait states.
// DMEM_BYTE_EN_EN replaces sub-word read-modify-write with lane-enabled writes.
module dmem_access_unit
    import dlx_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_req_if.slave   req_if,
    dmem_sram_if.master sram_if
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e             state_q, state_d;
    req_cap_t           cap_q, cap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
`ifdef DMEM_BYTE_EN_EN
    logic [LANES-1:0]   be_q, be_d;
    logic [LANES-1:0]   al_be;
`endif

    logic               idle;
    logic               misaligned;
    logic               at_limit;
    logic [1:0]         al_addr;
    logic [1:0]         al_size;
    logic               al_uns;
    logic [XLEN-1:0]    al_new;
    logic [XLEN-1:0]    al_load;
    logic [XLEN-1:0]    al_store;

    // In IDLE the aligner looks at the live request so lane-enabled stores can launch directly.
    assign idle    = (state_q == S_IDLE);
    assign al_addr = idle ? req_if.req_addr[1:0]  : cap_q.addr_lo;
    assign al_size = idle ? req_if.req_size       : cap_q.size;
    assign al_uns  = idle ? req_if.req_unsigned   : cap_q.uns;
    assign al_new  = idle ? req_if.req_wdata      : cap_q.wdata;

    dmem_lane_align u_align (
        .addr_lo_i    (al_addr),
        .size_i       (al_size),
        .uns_i        (al_uns),
        .old_word_i   (sram_if.sram_rdata),
        .new_data_i   (al_new),
        .load_data_o  (al_load),
`ifdef DMEM_BYTE_EN_EN
        .be_o         (al_be),
`endif
        .store_word_o (al_store)
    );

    assign misaligned = ((req_if.req_size == SZ_HALF) && req_if.req_addr[0]) ||
                        (req_if.req_size[1] && (req_if.req_addr[1:0] != 2'b00));
    assign at_limit   = (TIMEOUT != 0) && (cnt_q == CNT_LIM);

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
`ifdef DMEM_BYTE_EN_EN
        be_d    = be_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    cap_d.addr_lo = req_if.req_addr[1:0];
                    cap_d.size    = req_if.req_size;
                    cap_d.uns     = req_if.req_unsigned;
                    cap_d.wdata   = req_if.req_wdata;
                    addr_d        = req_if.req_addr[31:2];
                    if (misaligned) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!req_if.req_wr) begin
                        state_d = S_RD;
`ifdef DMEM_BYTE_EN_EN
                        be_d    = '1;
`endif
                    end else if (req_if.req_size[1]) begin
                        state_d = S_WR;
                        wdata_d = req_if.req_wdata;
`ifdef DMEM_BYTE_EN_EN
                        be_d    = '1;
`endif
                    end else begin
`ifdef DMEM_BYTE_EN_EN
                        state_d = S_WR;
                        wdata_d = al_store;
                        be_d    = al_be;
`else
                        state_d = S_RMW_RD;
`endif
                    end
                end
            end
            S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
                // Ack wins over the watchdog when both land in the same cycle.
                if (sram_if.sram_ack) begin
                    if (state_q == S_RMW_RD) begin
                        state_d = S_RMW_WR;
                        wdata_d = al_store;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = (state_q == S_RD) ? al_load : '0;
                    end
                end else if (at_limit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_d    = (state_d == S_RD) || (state_d == S_RMW_RD);
        wr_d    = (state_d == S_WR) || (state_d == S_RMW_WR);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef DMEM_BYTE_EN_EN
            be_q    <= be_d;
`endif
        end
    end

    // Stall covers the accept cycle and every strobe cycle; DONE lets the pipeline move.
    assign req_if.mem_stall  = (idle && req_if.req_valid) || rd_q || wr_q;
    assign req_if.resp_valid = valid_q;
    assign req_if.resp_rdata = rdata_q;
    assign req_if.resp_err   = err_q;

    assign sram_if.sram_addr  = addr_q;
    assign sram_if.sram_rd    = rd_q;
    assign sram_if.sram_wr    = wr_q;
    assign sram_if.sram_wdata = wdata_q;
`ifdef DMEM_BYTE_EN_EN
    assign sram_if.sram_be    = be_q;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed plus random bench for dmem_access_unit against a byte-level memory model.
module tb_dmem_access_unit;
    import dlx_mem_pkg::*;

    localparam int unsigned TO = 4;
`ifdef DMEM_BYTE_EN_EN
    localparam bit BE_MODE = 1'b1;
`else
    localparam bit BE_MODE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_req_if  rq ();
    dmem_sram_if sr ();

    dmem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_if  (rq),
        .sram_if (sr)
    );

    int errors = 0;
    int checks = 0;
    int step   = 0;

    // SRAM environment: 64 words covering byte addresses 0x1000-0x10FF.
    logic [31:0] mem [0:63];
    int          wait_rd = 0;
    int          wait_wr = 0;
    int          cyc     = 0;
    int          rd_hi = 0, wr_hi = 0, rd_acks = 0, wr_acks = 0;
    logic [29:0] last_addr = '0;
    logic [3:0]  last_be   = '0;

    assign sr.sram_ack   = (sr.sram_rd && (cyc == wait_rd)) || (sr.sram_wr && (cyc == wait_wr));
    assign sr.sram_rdata = mem[sr.sram_addr[5:0]];

    always @(posedge clk) begin
        if (sr.sram_rd) rd_hi = rd_hi + 1;
        if (sr.sram_wr) wr_hi = wr_hi + 1;
        if (sr.sram_ack) begin
            cyc <= 0;
            last_addr = sr.sram_addr;
`ifdef DMEM_BYTE_EN_EN
            last_be = sr.sram_be;
`else
            last_be = 4'hF;
`endif
            if (sr.sram_rd) rd_acks = rd_acks + 1;
            if (sr.sram_wr) begin
                wr_acks = wr_acks + 1;
                for (int j = 0; j < 4; j++)
                    if (last_be[j]) mem[sr.sram_addr[5:0]][j*8 +: 8] = sr.sram_wdata[j*8 +: 8];
            end
        end else if (sr.sram_rd || sr.sram_wr) begin
            cyc <= cyc + 1;
        end else begin
            cyc <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL step%0d %s: observed=%h expected=%h", step, tag, got, exp);
        end
    endtask

    // Reference model: memory as four big-endian bytes per word.
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
        h = {b[{a[1], 1'b0}], b[{a[1], 1'b1}]};
        if (sz == 2'd0) return uns ? {24'h0, b[a]} : {{24{b[a][7]}}, b[a]};
        if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
        logic [7:0] b [4];
        if (sz[1]) return d;
        for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
        if (sz == 2'd0) begin
            b[a] = d[7:0];
        end else begin
            b[{a[1], 1'b0}] = d[15:8];
            b[{a[1], 1'b1}] = d[7:0];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] a, input logic [1:0] sz);
        logic [3:0] be = '0;
        if (sz[1]) return 4'hF;
        be[3 - a] = 1'b1;
        if (sz == 2'd1) be[3 - {a[1], 1'b1}] = 1'b1;
        return be;
    endfunction

    function automatic bit m_mis(input logic [1:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a[0]) || (sz[1] && a != 2'd0);
    endfunction

    function automatic int dur(input int w);
        return (w < int'(TO)) ? w + 1 : int'(TO);
    endfunction

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int wrd, input int wwr);
        int          idx = int'(addr[7:2]);
        logic [31:0] old = mem[idx];
        logic [31:0] exp_word = old;
        logic [31:0] exp_rdata = '0;
        bit          exp_err = 0;
        int          exp_rdhi = 0, exp_wrhi = 0, exp_lat, n, stall_bad;
        step++;
        if (m_mis(addr[1:0], sz)) begin
            exp_err = 1;
        end else if (!wr) begin
            exp_rdhi  = dur(wrd);
            exp_err   = (wrd >= int'(TO));
            exp_rdata = exp_err ? 32'h0 : m_load(old, addr[1:0], sz, uns);
        end else if (sz[1] || BE_MODE) begin
            exp_wrhi = dur(wwr);
            exp_err  = (wwr >= int'(TO));
        end else begin
            exp_rdhi = dur(wrd);
            exp_err  = (wrd >= int'(TO));
            if (!exp_err) begin
                exp_wrhi = dur(wwr);
                exp_err  = (wwr >= int'(TO));
            end
        end
        if (wr && !exp_err) exp_word = m_store(old, addr[1:0], sz, wd);
        exp_lat = 1 + exp_rdhi + exp_wrhi;

        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_wr = wr; rq.req_size = sz; rq.req_unsigned = uns;
        rq.req_addr = addr; rq.req_wdata = wd;
        wait_rd = wrd; wait_wr = wwr;
        rd_hi = 0; wr_hi = 0; rd_acks = 0; wr_acks = 0;
        #1 check("stall_accept", 32'(rq.mem_stall), 32'd1);
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        n = 0; stall_bad = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rq.resp_valid === 1'b1) break;
            if (rq.mem_stall !== 1'b1) stall_bad++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("stall_held", 32'(stall_bad), 32'd0);
        check("stall_done", 32'(rq.mem_stall), 32'd0);
        check("resp_err", 32'(rq.resp_err), 32'(exp_err));
        if (!wr || exp_err) check("resp_rdata", rq.resp_rdata, exp_rdata);
        check("rd_cycles", 32'(rd_hi), 32'(exp_rdhi));
        check("wr_cycles", 32'(wr_hi), 32'(exp_wrhi));
        check("mem_word", mem[idx], exp_word);
        if (rd_acks + wr_acks > 0) begin
            check("sram_addr", 32'(last_addr), 32'(addr[31:2]));
            check("sram_be", 32'(last_be), 32'((wr && BE_MODE) ? m_be(addr[1:0], sz) : 4'hF));
        end
        @(negedge clk);
        check("resp_pulse", 32'(rq.resp_valid), 32'd0);
    endtask

    initial begin
        int n;
        int m;
        logic [31:0] snap;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rq.req_valid = 1'b0; rq.req_wr = 1'b0; rq.req_size = 2'b00;
        rq.req_unsigned = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(rq.resp_valid), 32'd0);
        check("rst_resp_err",   32'(rq.resp_err),   32'd0);
        check("rst_resp_rdata", rq.resp_rdata,      32'd0);
        check("rst_sram_rd",    32'(sr.sram_rd),    32'd0);
        check("rst_sram_wr",    32'(sr.sram_wr),    32'd0);
        check("rst_sram_addr",  32'(sr.sram_addr),  32'd0);
        check("rst_sram_wdata", sr.sram_wdata,      32'd0);
        check("rst_stall",      32'(rq.mem_stall),  32'd0);
        rst_n = 1'b1;

        // Sub-word and word loads, zero wait
        mem[0] = 32'h80FF7F01;
        run_req(1'b0, SZ_BYTE, 1'b0, 32'h1000, 32'h0, 0, 0);
        check("lb_value", rq.resp_rdata, 32'hFFFFFF80);
        run_req(1'b0, SZ_BYTE, 1'b1, 32'h1001, 32'h0, 0, 0);
        run_req(1'b0, SZ_HALF, 1'b0, 32'h1002, 32'h0, 0, 0);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, 0, 0);

        // Byte store with two wait states per strobe
        mem[0] = 32'h11223344;
        run_req(1'b1, SZ_BYTE, 1'b0, 32'h1002, 32'h000000AB, 2, 2);

        // Misaligned word load and half store
        run_req(1'b0, SZ_WORD, 1'b0, 32'h1002, 32'h0, 0, 0);
        run_req(1'b1, SZ_HALF, 1'b0, 32'h1001, 32'h1234, 0, 0);

        // Watchdog expiry, then a normal load
        run_req(1'b0, SZ_WORD, 1'b0, 32'h1004, 32'h0, 100, 0);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h1004, 32'h0, 0, 0);

        // Async reset while the write strobe is up
        step++;
        mem[2] = 32'hCAFEF00D;
        snap   = mem[2];
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_wr = 1'b1; rq.req_size = SZ_BYTE; rq.req_unsigned = 1'b0;
        rq.req_addr = 32'h1009; rq.req_wdata = 32'h5A;
        wait_rd = 0; wait_wr = 100;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        n = 0;
        while (sr.sram_wr !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_wr_up", 32'(sr.sram_wr), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_drop", 32'(sr.sram_wr),   32'd0);
        check("rst_mid_rd_low",  32'(sr.sram_rd),   32'd0);
        check("rst_mid_no_resp", 32'(rq.resp_valid), 32'd0);
        check("rst_mid_stall",   32'(rq.mem_stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_after", 32'(rq.resp_valid), 32'd0);
        check("rst_mid_mem",   mem[2], snap);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h1008, 32'h0, 0, 0);

        // Back-to-back loads with req_valid held through DONE
        step++;
        mem[3] = 32'h0badcafe;
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_wr = 1'b0; rq.req_size = SZ_WORD; rq.req_unsigned = 1'b0;
        rq.req_addr = 32'h100C; rq.req_wdata = '0;
        wait_rd = 0; wait_wr = 0;
        rd_acks = 0; wr_acks = 0;
        @(posedge clk);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rq.resp_valid === 1'b1) break;
        end
        check("b2b_a_lat",  32'(n), 32'd2);
        check("b2b_a_data", rq.resp_rdata, 32'h0badcafe);
        rq.req_size = SZ_BYTE; rq.req_unsigned = 1'b1; rq.req_addr = 32'h100D;
        m = 0;
        while (m < 20) begin
            @(negedge clk);
            m++;
            if (rq.resp_valid === 1'b1) break;
            if (m == 2) rq.req_valid = 1'b0;
        end
        rq.req_valid = 1'b0;
        check("b2b_b_lat",  32'(m), 32'd3);
        check("b2b_b_data", rq.resp_rdata, 32'h000000ad);
        repeat (3) @(negedge clk);
        check("b2b_rd_acks", 32'(rd_acks), 32'd2);
        check("b2b_wr_acks", 32'(wr_acks), 32'd0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            logic        rwr  = 1'($urandom);
            logic [1:0]  rsz  = 2'($urandom);
            logic        runs = 1'($urandom);
            logic [31:0] radr = 32'h1000 + 32'($urandom_range(0, 255));
            int          w1   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            int          w2   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            run_req(rwr, rsz, runs, radr, $urandom, w1, w2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
